// File: rtl/audio_session_ctrl.sv
// Session controller: boot sequencing (I2C init, SRAM clean), record/play/pause FSM, per-slot lengths.
// State, slot, length and stop/restart pulses are registered (1 cycle); no backpressure, keys are single-cycle pulses.
module audio_session_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int N_SLOTS = 4,
  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
  localparam int OFF_W  = ADDR_W - SLOT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_play,
  input  logic              i_key_rec,
  input  logic              i_key_stop,
  input  logic [SLOT_W-1:0] i_slot_sel,
  input  logic              i_loop,
  input  logic              i_backward,
  input  logic              i_i2c_finished,
  input  logic              i_clean_done,
  input  logic [ADDR_W-1:0] i_clean_addr,
  input  logic [OFF_W-1:0]  i_rec_off,
  input  logic [OFF_W-1:0]  i_play_off,
  output logic              o_i2c_start,
  output logic              o_clean_start,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic              o_dsp_restart,
  output logic [SLOT_W-1:0] o_slot,
  output logic [OFF_W-1:0]  o_slot_len,
  output logic [N_SLOTS-1:0] o_slot_valid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic              o_play_en,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_I2C        = 3'd1,
    ST_RECD       = 3'd2,
    ST_RECD_PAUSE = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5,
    ST_CLEAN      = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                boot_done_q, boot_done_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [OFF_W-1:0]    len_q [N_SLOTS];
  logic [OFF_W-1:0]    len_d [N_SLOTS];
  logic [N_SLOTS-1:0]  valid_q, valid_d;
  logic                rec_stop_q, rec_stop_d;
  logic                dsp_stop_q, dsp_stop_d;
  logic                dsp_restart_q, dsp_restart_d;
  logic [OFF_W-1:0]    rec_len;
  logic                play_end;

  always_comb begin
    state_d       = state_q;
    boot_done_d   = boot_done_q;
    slot_d        = slot_q;
    len_d         = len_q;
    valid_d       = valid_q;
    rec_stop_d    = 1'b0;
    dsp_stop_d    = 1'b0;
    dsp_restart_d = 1'b0;
    rec_len       = (i_rec_off > len_q[slot_q]) ? i_rec_off : len_q[slot_q];
    play_end      = i_backward ? (i_play_off == '0) : (i_play_off >= len_q[slot_q]);

    case (state_q)
      ST_IDLE: begin
        if (!boot_done_q) begin
          state_d = ST_I2C;
        end else if (i_key_stop) begin
          state_d = ST_IDLE;
        end else if (i_key_play) begin
          slot_d = i_slot_sel;
          if (valid_q[i_slot_sel]) state_d = ST_PLAY;
        end else if (i_key_rec) begin
          // Recording overwrites the slot, so its old length and flag go first.
          slot_d              = i_slot_sel;
          len_d[i_slot_sel]   = '0;
          valid_d[i_slot_sel] = 1'b0;
          state_d             = ST_RECD;
        end
      end
      ST_I2C: begin
        if (i_i2c_finished) state_d = ST_CLEAN;
      end
      ST_CLEAN: begin
        if (i_clean_done) begin
          state_d     = ST_IDLE;
          boot_done_d = 1'b1;
        end
      end
      ST_RECD: begin
        len_d[slot_q] = rec_len;
        if (rec_len != '0) valid_d[slot_q] = 1'b1;
        if (i_key_stop || (i_rec_off == {OFF_W{1'b1}})) begin
          rec_stop_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (i_key_rec) begin
          state_d = ST_RECD_PAUSE;
        end
      end
      ST_RECD_PAUSE: begin
        if (i_key_stop) begin
          rec_stop_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (i_key_rec) begin
          state_d = ST_RECD;
        end
      end
      ST_PLAY: begin
        if (i_key_stop || (play_end && !i_loop)) begin
          dsp_stop_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (play_end) begin
          dsp_restart_d = 1'b1;
        end else if (i_key_play) begin
          state_d = ST_PLAY_PAUSE;
        end
      end
      ST_PLAY_PAUSE: begin
        if (i_key_stop) begin
          dsp_stop_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (i_key_play) begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      boot_done_q   <= 1'b0;
      slot_q        <= '0;
      valid_q       <= '0;
      rec_stop_q    <= 1'b0;
      dsp_stop_q    <= 1'b0;
      dsp_restart_q <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) len_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      boot_done_q   <= boot_done_d;
      slot_q        <= slot_d;
      valid_q       <= valid_d;
      rec_stop_q    <= rec_stop_d;
      dsp_stop_q    <= dsp_stop_d;
      dsp_restart_q <= dsp_restart_d;
      for (int i = 0; i < N_SLOTS; i++) len_q[i] <= len_d[i];
    end
  end

  always_comb begin
    o_sram_addr = {slot_q, i_play_off};
    case (state_q)
      ST_CLEAN:               o_sram_addr = i_clean_addr;
      ST_RECD, ST_RECD_PAUSE: o_sram_addr = {slot_q, i_rec_off};
      default:                o_sram_addr = {slot_q, i_play_off};
    endcase
  end

  assign o_i2c_start   = (state_q == ST_I2C);
  assign o_clean_start = (state_q == ST_CLEAN);
  assign o_rec_start   = (state_q == ST_RECD);
  assign o_rec_pause   = (state_q == ST_RECD_PAUSE);
  assign o_dsp_start   = (state_q == ST_PLAY);
  assign o_dsp_pause   = (state_q == ST_PLAY_PAUSE);
  assign o_play_en     = (state_q == ST_PLAY);
  assign o_sram_we_n   = !((state_q == ST_RECD) || (state_q == ST_CLEAN));
  assign o_rec_stop    = rec_stop_q;
  assign o_dsp_stop    = dsp_stop_q;
  assign o_dsp_restart = dsp_restart_q;
  assign o_slot        = slot_q;
  assign o_slot_len    = len_q[slot_q];
  assign o_slot_valid  = valid_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_audio_session_ctrl.sv
// Scenario bench for audio_session_ctrl: expected snapshots are queued as stimulus is driven
// and popped against the DUT one cycle later.
module tb_audio_session_ctrl;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_key_play = 1'b0, i_key_rec = 1'b0, i_key_stop = 1'b0;
  logic [1:0]  i_slot_sel = '0;
  logic        i_loop = 1'b0, i_backward = 1'b0;
  logic        i_i2c_finished = 1'b0, i_clean_done = 1'b0;
  logic [19:0] i_clean_addr = '0;
  logic [17:0] i_rec_off = '0, i_play_off = '0;
  logic        o_i2c_start, o_clean_start, o_rec_start, o_rec_pause, o_rec_stop;
  logic        o_dsp_start, o_dsp_pause, o_dsp_stop, o_dsp_restart;
  logic [1:0]  o_slot;
  logic [17:0] o_slot_len;
  logic [3:0]  o_slot_valid;
  logic [19:0] o_sram_addr;
  logic        o_sram_we_n, o_play_en;
  logic [2:0]  o_state;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic        rs;
    logic        ds;
    logic        dr;
    logic [1:0]  slot;
    logic [3:0]  valid;
    logic [17:0] len;
    logic [7:0]  lvl;  // i2c, clean, rec_start, rec_pause, dsp_start, dsp_pause, play_en, we_n
  } obs_t;

  obs_t sb[$];
  obs_t e, o;

  audio_session_ctrl #(.ADDR_W(20), .N_SLOTS(4)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_key_play(i_key_play), .i_key_rec(i_key_rec), .i_key_stop(i_key_stop),
    .i_slot_sel(i_slot_sel), .i_loop(i_loop), .i_backward(i_backward),
    .i_i2c_finished(i_i2c_finished), .i_clean_done(i_clean_done),
    .i_clean_addr(i_clean_addr), .i_rec_off(i_rec_off), .i_play_off(i_play_off),
    .o_i2c_start(o_i2c_start), .o_clean_start(o_clean_start),
    .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause), .o_rec_stop(o_rec_stop),
    .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause), .o_dsp_stop(o_dsp_stop),
    .o_dsp_restart(o_dsp_restart), .o_slot(o_slot), .o_slot_len(o_slot_len),
    .o_slot_valid(o_slot_valid), .o_sram_addr(o_sram_addr), .o_sram_we_n(o_sram_we_n),
    .o_play_en(o_play_en), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk(logic [2:0] st, logic rs, logic ds, logic dr,
                              logic [1:0] sl, logic [3:0] v, logic [17:0] ln);
    obs_t r;
    logic [7:0] l;
    case (st)
      3'd0:    l = 8'h01;
      3'd1:    l = 8'h81;
      3'd2:    l = 8'h20;
      3'd3:    l = 8'h11;
      3'd4:    l = 8'h0B;
      3'd5:    l = 8'h05;
      3'd6:    l = 8'h40;
      default: l = 8'h00;
    endcase
    r = {st, rs, ds, dr, sl, v, ln, l};
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r = {o_state, o_rec_stop, o_dsp_stop, o_dsp_restart, o_slot, o_slot_valid, o_slot_len,
         o_i2c_start, o_clean_start, o_rec_start, o_rec_pause, o_dsp_start, o_dsp_pause,
         o_play_en, o_sram_we_n};
    return r;
  endfunction

  task automatic test_reset();
    i_rst = 1'b1; i_play_off = 18'h01234;
    sb.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0));
    tick(); tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_state got=%h exp=%h", o, e); end
    checks++;
    if (o_sram_addr !== 20'h01234) begin failures++; $display("FAIL reset_addr got=%h exp=%h", o_sram_addr, 20'h01234); end
  endtask

  task automatic test_boot();
    int exp_st[4] = '{1, 1, 6, 0};
    i_rst = 1'b0; i_clean_addr = 20'hABCDE;
    for (int i = 0; i < 4; i++) begin
      i_key_rec      = (i == 1);
      i_i2c_finished = (i == 2);
      i_clean_done   = (i == 3);
      sb.push_back(mk(exp_st[i][2:0], 0, 0, 0, 0, 4'h0, 0));
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL boot_step%0d got=%h exp=%h", i, o, e); end
      if (i == 2) begin
        checks++;
        if (o_sram_addr !== 20'hABCDE) begin failures++; $display("FAIL clean_addr got=%h exp=%h", o_sram_addr, 20'hABCDE); end
      end
    end
    i_key_rec = 1'b0; i_i2c_finished = 1'b0; i_clean_done = 1'b0;
  endtask

  task automatic test_record();
    logic [17:0] offs_a[3] = '{18'h000, 18'h040, 18'h080};
    logic [17:0] offs_b[2] = '{18'h0C0, 18'h100};
    i_slot_sel = 2'd2; i_rec_off = 18'h0; i_key_rec = 1'b1;
    sb.push_back(mk(2, 0, 0, 0, 2, 4'h0, 0));
    tick(); i_key_rec = 1'b0;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL rec_enter got=%h exp=%h", o, e); end
    for (int i = 0; i < 3; i++) begin
      i_rec_off = offs_a[i]; #1;
      checks++;
      if (o_sram_addr !== (20'h80000 | {2'b00, offs_a[i]})) begin
        failures++; $display("FAIL rec_addr got=%h exp=%h", o_sram_addr, 20'h80000 | {2'b00, offs_a[i]});
      end
      sb.push_back(mk(2, 0, 0, 0, 2, (offs_a[i] != 0) ? 4'h4 : 4'h0, offs_a[i]));
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL rec_sweep%0d got=%h exp=%h", i, o, e); end
    end
    i_key_rec = 1'b1;
    sb.push_back(mk(3, 0, 0, 0, 2, 4'h4, 18'h080));
    tick(); i_key_rec = 1'b0; i_rec_off = 18'h0FFF; #1;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL rec_pause got=%h exp=%h", o, e); end
    checks++;
    if (o_sram_addr !== 20'h80FFF) begin failures++; $display("FAIL pause_addr got=%h exp=%h", o_sram_addr, 20'h80FFF); end
    sb.push_back(mk(3, 0, 0, 0, 2, 4'h4, 18'h080));
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL pause_hold got=%h exp=%h", o, e); end
    i_rec_off = 18'h080; i_key_rec = 1'b1;
    sb.push_back(mk(2, 0, 0, 0, 2, 4'h4, 18'h080));
    tick(); i_key_rec = 1'b0;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL rec_resume got=%h exp=%h", o, e); end
    for (int i = 0; i < 2; i++) begin
      i_rec_off = offs_b[i];
      sb.push_back(mk(2, 0, 0, 0, 2, 4'h4, offs_b[i]));
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL rec_sweep_b%0d got=%h exp=%h", i, o, e); end
    end
    i_key_stop = 1'b1;
    sb.push_back(mk(0, 1, 0, 0, 2, 4'h4, 18'h100));
    sb.push_back(mk(0, 0, 0, 0, 2, 4'h4, 18'h100));
    tick(); i_key_stop = 1'b0;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL rec_stop got=%h exp=%h", o, e); end
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL rec_stop_end got=%h exp=%h", o, e); end
  endtask

  task automatic test_play_empty();
    i_slot_sel = 2'd1; i_key_play = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 1, 4'h4, 0));
    sb.push_back(mk(0, 0, 0, 0, 1, 4'h4, 0));
    for (int i = 0; i < 2; i++) begin
      tick(); i_key_play = 1'b0;
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL play_empty%0d got=%h exp=%h", i, o, e); end
    end
  endtask

  task automatic test_play();
    // {key_play, loop, backward, play_off} per cycle, with the expected snapshot after it
    logic [20:0] stim[13];
    obs_t exp[13];
    stim[0]  = {3'b110, 18'h000}; exp[0]  = mk(4, 0, 0, 0, 2, 4'h4, 18'h100);
    stim[1]  = {3'b010, 18'h0FF}; exp[1]  = mk(4, 0, 0, 0, 2, 4'h4, 18'h100);
    stim[2]  = {3'b010, 18'h100}; exp[2]  = mk(4, 0, 0, 1, 2, 4'h4, 18'h100);
    stim[3]  = {3'b010, 18'h000}; exp[3]  = mk(4, 0, 0, 0, 2, 4'h4, 18'h100);
    stim[4]  = {3'b110, 18'h000}; exp[4]  = mk(5, 0, 0, 0, 2, 4'h4, 18'h100);
    stim[5]  = {3'b010, 18'h100}; exp[5]  = mk(5, 0, 0, 0, 2, 4'h4, 18'h100);
    stim[6]  = {3'b110, 18'h100}; exp[6]  = mk(4, 0, 0, 0, 2, 4'h4, 18'h100);
    stim[7]  = {3'b000, 18'h100}; exp[7]  = mk(0, 0, 1, 0, 2, 4'h4, 18'h100);
    stim[8]  = {3'b000, 18'h100}; exp[8]  = mk(0, 0, 0, 0, 2, 4'h4, 18'h100);
    stim[9]  = {3'b101, 18'h050}; exp[9]  = mk(4, 0, 0, 0, 2, 4'h4, 18'h100);
    stim[10] = {3'b001, 18'h100}; exp[10] = mk(4, 0, 0, 0, 2, 4'h4, 18'h100);
    stim[11] = {3'b001, 18'h000}; exp[11] = mk(0, 0, 1, 0, 2, 4'h4, 18'h100);
    stim[12] = {3'b000, 18'h000}; exp[12] = mk(0, 0, 0, 0, 2, 4'h4, 18'h100);
    i_slot_sel = 2'd2;
    for (int i = 0; i < 13; i++) begin
      {i_key_play, i_loop, i_backward, i_play_off} = stim[i];
      sb.push_back(exp[i]);
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL play_step%0d got=%h exp=%h", i, o, e); end
      if (i == 0) begin
        i_play_off = 18'h0FF; #1; checks++;
        if (o_sram_addr !== 20'h800FF) begin failures++; $display("FAIL play_addr got=%h exp=%h", o_sram_addr, 20'h800FF); end
      end
    end
    i_key_play = 1'b0; i_loop = 1'b0; i_backward = 1'b0;
  endtask

  task automatic test_overflow();
    i_slot_sel = 2'd3; i_rec_off = 18'h0; i_key_rec = 1'b1;
    sb.push_back(mk(2, 0, 0, 0, 3, 4'h4, 0));
    tick(); i_key_rec = 1'b0; i_rec_off = 18'h3FFFF;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL ovf_enter got=%h exp=%h", o, e); end
    sb.push_back(mk(0, 1, 0, 0, 3, 4'hC, 18'h3FFFF));
    sb.push_back(mk(0, 0, 0, 0, 3, 4'hC, 18'h3FFFF));
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL ovf_stop%0d got=%h exp=%h", i, o, e); end
    end
    i_rec_off = 18'h0;
  endtask

  task automatic test_simultaneous();
    i_slot_sel = 2'd2; i_loop = 1'b1; i_play_off = 18'h0; i_key_play = 1'b1;
    sb.push_back(mk(4, 0, 0, 0, 2, 4'hC, 18'h100));
    tick(); i_key_play = 1'b0; i_key_stop = 1'b1; i_play_off = 18'h100;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL sim_enter got=%h exp=%h", o, e); end
    sb.push_back(mk(0, 0, 1, 0, 2, 4'hC, 18'h100));
    sb.push_back(mk(0, 0, 0, 0, 2, 4'hC, 18'h100));
    for (int i = 0; i < 2; i++) begin
      tick(); i_key_stop = 1'b0;
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin failures++; $display("FAIL stop_vs_end%0d got=%h exp=%h", i, o, e); end
    end
    i_play_off = 18'h010; i_key_play = 1'b1; i_key_rec = 1'b1;
    sb.push_back(mk(4, 0, 0, 0, 2, 4'hC, 18'h100));
    tick(); i_key_play = 1'b0; i_key_rec = 1'b0;
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL play_over_rec got=%h exp=%h", o, e); end
    i_rst = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 4'h0, 0));
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL rst_in_play got=%h exp=%h", o, e); end
    checks++;
    if (o_sram_addr !== 20'h00010) begin failures++; $display("FAIL rst_addr got=%h exp=%h", o_sram_addr, 20'h00010); end
    i_rst = 1'b0;
    sb.push_back(mk(1, 0, 0, 0, 0, 4'h0, 0));
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin failures++; $display("FAIL reboot got=%h exp=%h", o, e); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_record();
    test_play_empty();
    test_play();
    test_overflow();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_session_ctrl.md
# audio_session_ctrl

Parametrised session controller for the audio recorder/player. It sequences the boot (codec I2C init, then SRAM clean) and owns the record/play/pause state machine. The SRAM is split into N_SLOTS equal regions, with a recorded length kept for each slot, and playback can loop or stop at the end of a slot. It sits between the debounced key pulses and the I2C initializer, SRAM cleaner, recorder and DSP/player blocks, and drives the shared SRAM address and write-enable.

## Interface
- ADDR_W, 20, SRAM word-address width.
- N_SLOTS, 4, number of slots; power of two, 1..16. SLOT_W = max(1, $clog2(N_SLOTS)).
- OFF_W, ADDR_W-SLOT_W (derived), per-slot offset width. Slot depth = 2^OFF_W.

- i_clk  in  1  system clock; only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_key_play, i_key_rec, i_key_stop  in  1 each  single-cycle key pulses.
- i_slot_sel  in  SLOT_W  requested slot.
- i_loop  in  1  loop playback at the slot end.
- i_backward  in  1  backward playback (the DSP decrements the offset).
- i_i2c_finished  in  1  I2C init done (level).
- i_clean_done  in  1  SRAM clean done (level).
- i_clean_addr  in  ADDR_W  cleaner's full SRAM address.
- i_rec_off  in  OFF_W  recorder's current write offset.
- i_play_off  in  OFF_W  DSP's current read offset.
- o_i2c_start, o_clean_start  out  1  held high while in I2C / CLEAN.
- o_rec_start, o_rec_pause  out  1  levels; o_rec_stop  out  1  one-cycle pulse.
- o_dsp_start, o_dsp_pause  out  1  levels; o_dsp_stop, o_dsp_restart  out  1  one-cycle pulses.
- o_slot  out  SLOT_W  active slot.
- o_slot_len  out  OFF_W  recorded length of the active slot (last valid offset).
- o_slot_valid  out  N_SLOTS  per-slot "contains audio" flags.
- o_sram_addr  out  ADDR_W  CLEAN: i_clean_addr; RECD and RECD_PAUSE: {o_slot, i_rec_off}; otherwise {o_slot, i_play_off}.
- o_sram_we_n  out  1  low only in RECD or CLEAN.
- o_play_en  out  1  high only in PLAY.
- o_state  out  3  IDLE=0, I2C=1, RECD=2, RECD_PAUSE=3, PLAY=4, PLAY_PAUSE=5, CLEAN=6.

## Operation
- States: IDLE, I2C, CLEAN, RECD, RECD_PAUSE, PLAY, PLAY_PAUSE.
- Boot: a boot_done flag is cleared by reset.
  - IDLE with boot_done=0 goes to I2C.
  - I2C goes to CLEAN on i_i2c_finished.
  - CLEAN goes to IDLE on i_clean_done and sets boot_done.
  - Keys are ignored until boot_done=1.
- Keys in IDLE (boot_done=1):
  - Key priority: stop > play > rec.
  - i_key_play: latches o_slot <= i_slot_sel, then goes to PLAY only if that slot's valid flag is set. Otherwise it stays in IDLE; o_slot still updates.
  - i_key_rec: latches the slot, clears that slot's length and valid flag (overwrite), then goes to RECD.
- Record:
  - RECD: i_key_rec goes to RECD_PAUSE; RECD_PAUSE: i_key_rec goes back to RECD.
  - i_key_stop in either state pulses o_rec_stop and goes to IDLE.
  - In RECD: slot_len <= max(slot_len, i_rec_off), and the valid flag is set once slot_len > 0.
  - Slot full: i_rec_off == 2^OFF_W-1 in RECD acts as an automatic stop.
- Play:
  - PLAY: i_key_play goes to PLAY_PAUSE; PLAY_PAUSE: i_key_play goes back to PLAY.
  - i_key_stop in either state pulses o_dsp_stop and goes to IDLE.
  - End of slot, checked only in PLAY: forward playback ends at i_play_off >= slot_len; backward playback ends at i_play_off == 0.
  - At end with i_loop=1: pulse o_dsp_restart and stay in PLAY.
  - At end with i_loop=0: pulse o_dsp_stop and go to IDLE.
  - An i_key_stop in the same cycle as end-of-slot wins: a single o_dsp_stop pulse, and no restart.
- i_slot_sel is ignored outside IDLE.
- Lengths and valid flags persist across sessions; only reset or a new recording into a slot clears them.

## Timing
- Reset (sampled at a posedge with i_rst=1): state IDLE, boot_done=0, all slot_len=0, o_slot_valid=0, o_slot=0.
  - Every control output is 0, except o_sram_we_n=1.
  - o_sram_addr equals {0, i_play_off}.
- Reset mid-operation aborts immediately with no stop pulse; after release the boot sequence reruns.
- State, o_slot, slot_len and valid flags are registered.
  - A key pulse in cycle n changes o_state in cycle n+1.
- Level controls are decoded from the registered state: o_i2c_start, o_clean_start, o_rec_start (RECD), o_rec_pause (RECD_PAUSE), o_dsp_start (PLAY), o_dsp_pause (PLAY_PAUSE), o_play_en, o_sram_we_n.
- o_rec_stop, o_dsp_stop and o_dsp_restart are registered pulses, exactly 1 cycle long, in the cycle after the triggering event (the same cycle o_state reaches IDLE).
- o_sram_addr is combinational from the registered state and the offset inputs.
- The slot_len update uses the i_rec_off sampled in each RECD cycle; latency 1 cycle.

## Test plan
- Boot: release reset → o_state goes 0→1 next cycle; i_i2c_finished=1 → state 6, o_clean_start=1; i_clean_done=1 → state 0, keys accepted.
- Record slot 2 (N_SLOTS=4, ADDR_W=20): sweep i_rec_off 0..0x100 → o_sram_addr=0x80000+off, o_sram_we_n=0; i_key_stop → o_rec_stop one cycle, o_slot_valid=4'b0100, o_slot_len=0x100.
- Play an empty slot 1: i_key_play → stays IDLE, o_slot=1, no dsp outputs asserted.
- Play slot 2, i_loop=1: i_play_off reaches 0x100 → one o_dsp_restart pulse, stays PLAY. Repeat with i_loop=0 → o_dsp_stop pulse, state IDLE.
- Slot overflow: in RECD, i_rec_off=0x3FFFF → o_rec_stop pulse, IDLE, o_slot_len=0x3FFFF.
- Simultaneous events:
  - i_key_stop with end-of-slot (i_loop=1) → single o_dsp_stop, no restart.
  - i_key_play with i_key_rec in IDLE → PLAY.
  - i_rst asserted in PLAY → all outputs return to reset values and the boot sequence reruns.
